// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and encodings for the memory-stage load/store unit.
// Imported by the LSU top, its interface users and the load extender.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Stores only have signed-size encodings; loads add the unsigned ones.
    function automatic logic f3_legal(input logic [2:0] f3,
                                      input logic       is_store);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/ready port between the LSU (master) and memory.
// Request fields are held stable by the master until ready is seen.
interface mem_stage_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_ready;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_load_extend.sv
// Selects the addressed byte/half of a read word and sign/zero extends it.
// Purely combinational; word loads pass through untouched.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_f3,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        unique case (i_off)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data = i_rdata;
        unique case (1'b1)
            (i_f3 == F3_B):  o_data = {{24{w_byte[7]}}, w_byte};
            (i_f3 == F3_BU): o_data = {24'h0, w_byte};
            (i_f3 == F3_H):  o_data = {{16{w_half[15]}}, w_half};
            (i_f3 == F3_HU): o_data = {16'h0, w_half};
            default:         o_data = i_rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: validates M-stage accesses, drives the req/ready data
// port, builds store lanes, and returns aligned/extended load data.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic            MemWriteM,
    input  logic            ValidM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    mem_stage_lsu_if.master dmem,
    output logic            StallM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            MemFaultM
);
    lsu_state_t        r_state;
    lsu_state_t        w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic [2:0]        r_f3;
    logic [31:0]       r_rdata;

    logic              w_is_ld;
    logic              w_mem_op;
    logic              w_f3_ok;
    logic              w_misal;
    logic              w_fault;
    logic              w_go;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ext;
    logic              w_unused_ok;

    assign w_unused_ok = &{1'b0, RegWriteM};

    assign w_is_ld  = (ResultSrcM == RES_MEM);
    assign w_mem_op = ValidM & (MemWriteM | w_is_ld);
    assign w_f3_ok  = f3_legal(funct3M, MemWriteM);
    assign w_misal  = ((funct3M[1:0] == 2'b01) & ALUResultM[0])
                    | ((funct3M[1:0] == 2'b10) & (|ALUResultM[1:0]));
    assign w_fault  = w_mem_op & (~w_f3_ok | w_misal);
    assign w_go     = w_mem_op & ~w_fault;

    // Store lanes; loads always request the full word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM[31:0];
        if (MemWriteM) begin
            unique case (1'b1)
                (funct3M == F3_B): begin
                    w_be    = 4'b0001 << ALUResultM[1:0];
                    w_wdata = {4{WriteDataM[7:0]}};
                end
                (funct3M == F3_H): begin
                    w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = WriteDataM[31:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_go ? REQ : IDLE;
            REQ:     w_next = dmem.dmem_ready ? DONE : REQ;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
        dmem.dmem_be    = r_be;
        dmem.dmem_wdata = r_wdata;
        StallM          = 1'b0;
        ReadDataM       = '0;
        MemFaultM       = 1'b0;
        unique case (r_state)
            IDLE: begin
                StallM    = w_go;
                MemFaultM = w_fault;
            end
            REQ: begin
                dmem.dmem_req = 1'b1;
                dmem.dmem_we  = r_we;
                StallM        = 1'b1;
            end
            DONE: begin
                ReadDataM = w_ext;
            end
            default: begin
                StallM = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_rdata <= '0;
        end else begin
            if ((r_state == IDLE) && w_go) begin
                r_addr  <= ALUResultM[ADDR_W-1:0];
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_we    <= MemWriteM;
                r_f3    <= funct3M;
            end
            if ((r_state == REQ) && dmem.dmem_ready) begin
                r_rdata <= dmem.dmem_rdata;
            end
        end
    end

    load_extend u_ext (
        .i_rdata (r_rdata),
        .i_off   (r_addr[1:0]),
        .i_f3    (r_f3),
        .o_data  (w_ext)
    );
endmodule
